// File: rtl/puf_pkg.sv
// Shared types for the PUF response serial transmitter.
package puf_pkg;

   localparam int PUF_RESP_W = 256;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/puf_bit_timer.sv
// Bit-period divider: tick marks the last clock of each DIV-clock period.
module puf_bit_timer
   import puf_pkg::*;
#(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic run,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] div_cnt_q;
   logic [CW-1:0] div_cnt_d;

   assign tick = run && (div_cnt_q == LAST);

   always_comb begin
      div_cnt_d = div_cnt_q;
      if (clear) begin
         div_cnt_d = '0;
      end else if (run) begin
         div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

endmodule

// File: rtl/puf_serializer.sv
// Parallel-in, LSB-first serial-out transmitter for PUF response words.
module puf_serializer
   import puf_pkg::*;
#(
   parameter int WIDTH = PUF_RESP_W,
   parameter int DIV   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] p_in,
   input  logic             abort,
   output logic             s_out,
   output logic             s_en,
   output logic             busy,
   output logic             done
);

   localparam int BW = $clog2(WIDTH);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   state_e           state_q;
   state_e           state_d;
   logic [WIDTH-1:0] shreg_q;
   logic [WIDTH-1:0] shreg_d;
   logic [BW-1:0]    bit_cnt_q;
   logic [BW-1:0]    bit_cnt_d;
   logic             run;
   logic             clear;
   logic             tick;

   assign run   = (state_q == SHIFT);
   assign clear = abort || !run;

   puf_bit_timer #(
      .DIV (DIV)
   ) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .run   (run),
      .tick  (tick)
   );

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (load_valid) begin
               shreg_d   = p_in;
               bit_cnt_d = '0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            if (tick) begin
               shreg_d   = shreg_q >> 1;
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // abort overrides any load, strobe or DONE exit in the same cycle
      if (abort) begin
         state_d   = IDLE;
         shreg_d   = shreg_q;
         bit_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   assign load_ready = (state_q == IDLE);
   assign s_out      = run && shreg_q[0];
   assign s_en       = tick;
   assign busy       = (state_q == SHIFT) || (state_q == DONE);
   assign done       = (state_q == DONE);

endmodule

// File: tb/tb_puf_serializer.sv
// Randomized bench for puf_serializer at DIV = 1, 3 and 4.
module tb_puf_serializer;

   localparam int W = 256;
   localparam int DV [3] = '{1, 3, 4};

   logic           clk;
   logic           rst_n;
   logic           lv [3];
   logic           ab [3];
   logic [W-1:0]   pin [3];
   logic           lr [3];
   logic           so [3];
   logic           se [3];
   logic           bz [3];
   logic           dn [3];

   int checks;
   int errors;

   puf_serializer #(.WIDTH(W), .DIV(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .load_valid(lv[0]),
      .load_ready(lr[0]), .p_in(pin[0]), .abort(ab[0]),
      .s_out(so[0]), .s_en(se[0]), .busy(bz[0]), .done(dn[0])
   );

   puf_serializer #(.WIDTH(W), .DIV(3)) u_d3 (
      .clk(clk), .rst_n(rst_n), .load_valid(lv[1]),
      .load_ready(lr[1]), .p_in(pin[1]), .abort(ab[1]),
      .s_out(so[1]), .s_en(se[1]), .busy(bz[1]), .done(dn[1])
   );

   puf_serializer #(.WIDTH(W), .DIV(4)) u_d4 (
      .clk(clk), .rst_n(rst_n), .load_valid(lv[2]),
      .load_ready(lr[2]), .p_in(pin[2]), .abort(ab[2]),
      .s_out(so[2]), .s_en(se[2]), .busy(bz[2]), .done(dn[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [W-1:0] got,
                        input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] rnd_word();
      logic [W-1:0] r;
      for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic chk_reset_outs(input int k, input string tag);
      check({tag, "_rdy"}, lr[k], 1);
      check({tag, "_outs"}, {so[k], se[k], bz[k], dn[k]}, 0);
   endtask

   // Cycle c (1-based after the accept edge): bits held for d clocks,
   // strobe on the last clock, then one DONE cycle, then IDLE.
   task automatic xfer(input int k, input logic [W-1:0] w,
                       input int ab_at, input int rs_at);
      int d, tot, nstr, bad_en, bad_so, bad_dn, bad_bz;
      logic e_en, e_so, e_dn, e_bz;
      logic [W-1:0] rx;
      d = DV[k];
      tot = W * d;
      nstr = 0;
      bad_en = 0; bad_so = 0; bad_dn = 0; bad_bz = 0;
      rx = '0;
      @(negedge clk);
      check("idle_rdy", lr[k], 1);
      lv[k] = 1'b1;
      pin[k] = w;
      @(negedge clk);
      lv[k] = 1'b0;
      pin[k] = rnd_word();
      check("rdy_fall", lr[k], 0);
      for (int c = 1; c <= tot + 2; c++) begin
         if (c > 1) @(negedge clk);
         if (rs_at == c) begin
            #2 rst_n = 1'b0;
            #1 chk_reset_outs(k, "rst_async");
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         if (c <= tot) begin
            e_en = ((c - 1) % d) == d - 1;
            e_so = w[(c - 1) / d];
            e_dn = 1'b0;
            e_bz = 1'b1;
         end else if (c == tot + 1) begin
            e_en = 1'b0; e_so = 1'b0; e_dn = 1'b1; e_bz = 1'b1;
         end else begin
            e_en = 1'b0; e_so = 1'b0; e_dn = 1'b0; e_bz = 1'b0;
         end
         if (se[k] !== e_en) bad_en++;
         if (so[k] !== e_so) bad_so++;
         if (dn[k] !== e_dn) bad_dn++;
         if (bz[k] !== e_bz) bad_bz++;
         if (se[k] === 1'b1) begin
            rx = {so[k], rx[W-1:1]};
            nstr++;
         end
         if (ab_at > 0 && nstr == ab_at && se[k] === 1'b1) begin
            check("pre_abort_en", bad_en, 0);
            check("pre_abort_so", bad_so, 0);
            ab[k] = 1'b1;
            @(negedge clk);
            ab[k] = 1'b0;
            @(negedge clk);
            check("abort_rdy", lr[k], 1);
            check("abort_busy", bz[k], 0);
            bad_dn = 0;
            for (int j = 0; j < 4 * d + 4; j++) begin
               if (dn[k] !== 1'b0 || se[k] !== 1'b0) bad_dn++;
               @(negedge clk);
            end
            check("abort_nodone", bad_dn, 0);
            return;
         end
      end
      check("s_en_seq", bad_en, 0);
      check("s_out_seq", bad_so, 0);
      check("done_time", bad_dn, 0);
      check("busy_seq", bad_bz, 0);
      check("strobes", nstr, W);
      check("loopback", rx, w);
   endtask

   // load_valid held high: model accepts at the start of every
   // W*DIV+2 cycle period and ignores p_in otherwise.
   task automatic streaming(input int k, input int nxf);
      int p, bad_rdy, ndone;
      logic [W-1:0] q [$];
      logic [W-1:0] rx;
      logic [W-1:0] exp;
      p = W * DV[k] + 2;
      bad_rdy = 0;
      ndone = 0;
      rx = '0;
      @(negedge clk);
      lv[k] = 1'b1;
      for (int n = 0; n < nxf * p; n++) begin
         if (lr[k] !== ((n % p) == 0)) bad_rdy++;
         if (se[k] === 1'b1) rx = {so[k], rx[W-1:1]};
         if (dn[k] === 1'b1) begin
            exp = (q.size() > 0) ? q.pop_front() : '0;
            check("stream_word", rx, exp);
            ndone++;
         end
         pin[k] = rnd_word();
         if ((n % p) == 0) begin
            q.push_back(pin[k]);
            rx = '0;
         end
         @(negedge clk);
      end
      lv[k] = 1'b0;
      check("stream_rdy", bad_rdy, 0);
      check("stream_cnt", ndone, nxf);
   endtask

   initial begin
      logic [W-1:0] a5;
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         lv[k] = 1'b0;
         ab[k] = 1'b0;
         pin[k] = '0;
      end
      #1;
      for (int k = 0; k < 3; k++) chk_reset_outs(k, "reset");
      #20;
      @(negedge clk);
      rst_n = 1'b1;

      xfer(0, 256'h1, 0, 0);
      a5 = {32{8'hA5}};
      xfer(2, a5, 0, 0);
      xfer(0, rnd_word(), 0, 0);
      xfer(1, rnd_word(), 0, 0);

      xfer(2, rnd_word(), 100, 0);
      xfer(2, '1, 0, 0);
      xfer(0, rnd_word(), 100, 0);

      @(negedge clk);
      lv[1] = 1'b1;
      ab[1] = 1'b1;
      pin[1] = rnd_word();
      @(negedge clk);
      lv[1] = 1'b0;
      ab[1] = 1'b0;
      check("abort_wins_rdy", lr[1], 1);
      check("abort_wins_busy", bz[1], 0);

      streaming(0, 3);

      xfer(1, rnd_word(), 0, 50);
      for (int k = 0; k < 3; k++) chk_reset_outs(k, "post_rst");
      xfer(1, rnd_word(), 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
